// File: rtl/opl3_pkg.sv
// Shared OPL3 audio-path definitions: sample width, I2S receiver state encoding
// and the slot-length limit used for loss-of-sync detection.
package opl3_pkg;

  localparam int SAMPLE_WIDTH      = 16;
  localparam int I2S_MAX_SLOT_BITS = 64;

  typedef enum logic {
    HUNT    = 1'b0,
    RECEIVE = 1'b1
  } i2s_rx_state_e;

endpackage

// File: rtl/i2s_rx_if.sv
// I2S receive link bundle: serial pins toward the receiver and decoded sample
// outputs back from it.
interface i2s_rx_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                    sclk;
  logic                    ws;
  logic                    sd;
  logic [SAMPLE_WIDTH-1:0] left_channel;
  logic [SAMPLE_WIDTH-1:0] right_channel;
  logic                    sample_valid;
  logic                    sync_lost;

  modport master (
    output sclk, ws, sd,
    input  left_channel, right_channel, sample_valid, sync_lost
  );

  modport slave (
    input  sclk, ws, sd,
    output left_channel, right_channel, sample_valid, sync_lost
  );
endinterface

// File: rtl/synchronizer.sv
// Multi-bit flop-chain synchronizer; each bit is independent, so only use it for
// signals whose bits need no mutual coherence.
module synchronizer #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples the bit clock in the clk domain, frames left/right
// slots on word-select transitions and presents MSB-aligned sample pairs.
module i2s_rx
  import opl3_pkg::*;
#(
  parameter int SAMPLE_WIDTH = opl3_pkg::SAMPLE_WIDTH,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i2s_sclk,
  input  logic                    i2s_ws,
  input  logic                    i2s_sd,
  output logic [SAMPLE_WIDTH-1:0] left_channel,
  output logic [SAMPLE_WIDTH-1:0] right_channel,
  output logic                    sample_valid,
  output logic                    sync_lost
);

  localparam int CNT_W = $clog2(I2S_MAX_SLOT_BITS + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [SAMPLE_WIDTH-1:0] word_t;
  localparam cnt_t LAST_BIT  = cnt_t'(I2S_MAX_SLOT_BITS - 1);
  localparam cnt_t WORD_BITS = cnt_t'(SAMPLE_WIDTH);

  // Bit pos of a slot lands at word bit SAMPLE_WIDTH-1-pos; later bits fall off.
  function automatic word_t place_bit(input word_t word, input cnt_t pos, input logic b);
    word_t one_bit;
    one_bit = word_t'(b);
    if (pos < WORD_BITS) place_bit = word | (one_bit << (WORD_BITS - cnt_t'(1) - pos));
    else                 place_bit = word;
  endfunction

  // Assert asynchronously, release two clk edges after reset_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [2:0] sync_w;
  logic       sclk_s, ws_s, sd_s;

  synchronizer #(.WIDTH(3), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  ({i2s_sclk, i2s_ws, i2s_sd}),
    .q_o  (sync_w)
  );
  assign {sclk_s, ws_s, sd_s} = sync_w;

  // Edge-detect stage: registers the rise strobe together with its ws/sd pair.
  logic sclk_prev_q, rise_q, ws_smp_q, sd_smp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      ws_smp_q    <= 1'b0;
      sd_smp_q    <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      rise_q      <= sclk_s & ~sclk_prev_q;
      ws_smp_q    <= ws_s;
      sd_smp_q    <= sd_s;
    end
  end

  // Framing stage.
  i2s_rx_state_e state_q, state_d;
  logic          have_prev_q, have_prev_d;
  logic          ws_prev_q, ws_prev_d;
  logic          have_left_q, have_left_d;
  cnt_t          cnt_q, cnt_d;
  word_t         slot_q, slot_d;
  word_t         hold_l_q, hold_l_d;
  word_t         left_q, left_d;
  word_t         right_q, right_d;
  logic          valid_q, valid_d;
  logic          lost_q, lost_d;
  logic          trans;
  word_t         slot_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      have_prev_q <= 1'b0;
      ws_prev_q   <= 1'b0;
      have_left_q <= 1'b0;
      cnt_q       <= '0;
      slot_q      <= '0;
      hold_l_q    <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      have_prev_q <= have_prev_d;
      ws_prev_q   <= ws_prev_d;
      have_left_q <= have_left_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      hold_l_q    <= hold_l_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      lost_q      <= lost_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    have_prev_d = have_prev_q;
    ws_prev_d   = ws_prev_q;
    have_left_d = have_left_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    hold_l_d    = hold_l_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;
    lost_d      = lost_q;
    // The very first edge after reset has no predecessor, so it cannot be a transition.
    trans       = have_prev_q && (ws_smp_q != ws_prev_q);
    slot_next   = place_bit(slot_q, cnt_q, sd_smp_q);

    if (rise_q) begin
      have_prev_d = 1'b1;
      ws_prev_d   = ws_smp_q;
      case (state_q)
        HUNT: begin
          if (trans) begin
            state_d     = RECEIVE;
            cnt_d       = '0;
            slot_d      = '0;
            have_left_d = 1'b0;
          end
        end
        RECEIVE: begin
          if (trans) begin
            cnt_d  = '0;
            slot_d = '0;
            // The ending slot belongs to the previous ws value.
            if (!ws_prev_q) begin
              hold_l_d    = slot_next;
              have_left_d = 1'b1;
            end else if (have_left_q) begin
              left_d      = hold_l_q;
              right_d     = slot_next;
              valid_d     = 1'b1;
              have_left_d = 1'b0;
            end
          end else if (cnt_q == LAST_BIT) begin
            lost_d      = 1'b1;
            state_d     = HUNT;
            cnt_d       = '0;
            slot_d      = '0;
            have_left_d = 1'b0;
          end else begin
            cnt_d  = cnt_q + cnt_t'(1);
            slot_d = slot_next;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign left_channel  = left_q;
  assign right_channel = right_q;
  assign sample_valid  = valid_q;
  assign sync_lost     = lost_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: bit-banged I2S frames, vector table, random frames against
// an arithmetic left-alignment model, and resync/reset corner sequences.
module tb_i2s_rx;
  import opl3_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  i2s_rx_if #(.SAMPLE_WIDTH(W)) bus ();

  i2s_rx #(.SAMPLE_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i2s_sclk     (bus.sclk),
    .i2s_ws       (bus.ws),
    .i2s_sd       (bus.sd),
    .left_channel (bus.left_channel),
    .right_channel(bus.right_channel),
    .sample_valid (bus.sample_valid),
    .sync_lost    (bus.sync_lost)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;
  int lat;

  always @(negedge clk) if (bus.sample_valid) pulse_cnt++;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One sclk period: data set while low (4 clk), high for 6 clk; lat records the
  // clk count from the sclk rise to the first sample_valid seen in the high phase.
  task automatic sclk_edge(input logic wsv, input logic sdv);
    @(negedge clk);
    bus.ws = wsv;
    bus.sd = sdv;
    repeat (3) @(negedge clk);
    bus.sclk = 1'b1;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.sample_valid && lat == 0) lat = k;
    end
    @(negedge clk);
    bus.sclk = 1'b0;
  endtask

  // A slot on channel wsv: MSB..bit1 under wsv, the LSB on the ws flip.
  task automatic send_slot(input logic wsv, input logic [63:0] d, input int n);
    for (int i = n - 1; i >= 1; i--) sclk_edge(wsv, d[i]);
    sclk_edge(~wsv, d[0]);
  endtask

  task automatic send_frame(input logic [63:0] l, input logic [63:0] r, input int n);
    send_slot(1'b0, l, n);
    send_slot(1'b1, r, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Reference: the n-bit word read MSB first, left-aligned into W bits.
  function automatic logic [W-1:0] model_word(input logic [63:0] d, input int n);
    logic [63:0] m;
    m = (n >= 64) ? d : (d & ((64'd1 << n) - 64'd1));
    if (n >= W) return W'(m >> (n - W));
    else        return W'(m << (W - n));
  endfunction

  typedef struct {
    int          n;
    logic [63:0] l;
    logic [63:0] r;
    logic [W-1:0] el;
    logic [W-1:0] er;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int p0, nl, nr;
    logic [63:0] dl, dr;
    logic [W-1:0] prev_l;

    vecs[0] = '{16, 64'hA5C3, 64'h3C5A, 16'hA5C3, 16'h3C5A};
    vecs[1] = '{24, 64'h123456, 64'hFEDCBA, 16'h1234, 16'hFEDC};
    vecs[2] = '{8, 64'hAB, 64'hCD, 16'hAB00, 16'hCD00};
    vecs[3] = '{32, 64'hDEADBEEF, 64'h01234567, 16'hDEAD, 16'h0123};
    vecs[4] = '{64, 64'hCAFE_0000_0000_0001, 64'h1357_FFFF_FFFF_FFFF, 16'hCAFE, 16'h1357};
    vecs[5] = '{1, 64'h1, 64'h0, 16'h8000, 16'h0000};

    bus.sclk = 1'b0;
    bus.ws   = 1'b0;
    bus.sd   = 1'b0;
    reset_n  = 1'b0;
    #22;
    chk("reset_left", 64'(bus.left_channel), 64'h0);
    chk("reset_right", 64'(bus.right_channel), 64'h0);
    chk("reset_valid", 64'(bus.sample_valid), 64'h0);
    chk("reset_lost", 64'(bus.sync_lost), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Preamble: a right-slot LSB edge so the receiver leaves HUNT before left.
    sclk_edge(1'b1, 1'b0);
    sclk_edge(1'b0, 1'b0);
    chk("preamble_pulses", 64'(pulse_cnt), 64'd0);

    for (int v = 0; v < 6; v++) begin
      p0 = pulse_cnt;
      send_frame(vecs[v].l, vecs[v].r, vecs[v].n);
      chk($sformatf("vec%0d_pulses", v), 64'(pulse_cnt - p0), 64'd1);
      chk($sformatf("vec%0d_left", v), 64'(bus.left_channel), 64'(vecs[v].el));
      chk($sformatf("vec%0d_right", v), 64'(bus.right_channel), 64'(vecs[v].er));
      chk($sformatf("vec%0d_latency", v), 64'(lat), 64'd4);
    end
    chk("no_lost_64bit", 64'(bus.sync_lost), 64'h0);

    // A completed left slot alone must not move left_channel.
    prev_l = bus.left_channel;
    p0 = pulse_cnt;
    send_slot(1'b0, 64'h5A5A, 16);
    chk("left_only_hold", 64'(bus.left_channel), 64'(prev_l));
    chk("left_only_pulses", 64'(pulse_cnt - p0), 64'd0);
    send_slot(1'b1, 64'h0F0F, 16);
    chk("split_pulses", 64'(pulse_cnt - p0), 64'd1);
    chk("split_left", 64'(bus.left_channel), 64'h5A5A);
    chk("split_right", 64'(bus.right_channel), 64'h0F0F);

    // Counting sequence as an I2S transmitter would emit it.
    for (int k = 0; k < 6; k++) begin
      p0 = pulse_cnt;
      send_frame(64'(16'h0001 + k), 64'(16'h8000 + k), 16);
      chk($sformatf("loop%0d_pulses", k), 64'(pulse_cnt - p0), 64'd1);
      chk($sformatf("loop%0d_left", k), 64'(bus.left_channel), 64'(16'h0001 + k));
      chk($sformatf("loop%0d_right", k), 64'(bus.right_channel), 64'(16'h8000 + k));
    end

    for (int k = 0; k < 12; k++) begin
      nl = $urandom_range(1, 64);
      nr = $urandom_range(1, 64);
      dl = {$urandom(), $urandom()};
      dr = {$urandom(), $urandom()};
      p0 = pulse_cnt;
      send_slot(1'b0, dl, nl);
      send_slot(1'b1, dr, nr);
      chk($sformatf("rnd%0d_pulses", k), 64'(pulse_cnt - p0), 64'd1);
      chk($sformatf("rnd%0d_left", k), 64'(bus.left_channel), 64'(model_word(dl, nl)));
      chk($sformatf("rnd%0d_right", k), 64'(bus.right_channel), 64'(model_word(dr, nr)));
      chk($sformatf("rnd%0d_latency", k), 64'(lat), 64'd4);
    end
    chk("rnd_no_lost", 64'(bus.sync_lost), 64'h0);

    // Start mid-right slot, then an overlong left slot.
    do_reset();
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) sclk_edge(1'b1, 1'($urandom_range(0, 1)));
    for (int i = 1; i <= 70; i++) begin
      sclk_edge(1'b0, 1'($urandom_range(0, 1)));
      if (i == 64) chk("lost_before_limit", 64'(bus.sync_lost), 64'h0);
      if (i == 65) chk("lost_at_limit", 64'(bus.sync_lost), 64'h1);
    end
    chk("lost_no_pulse", 64'(pulse_cnt - p0), 64'd0);
    chk("lost_left_zero", 64'(bus.left_channel), 64'h0);
    send_frame(64'h1111, 64'h2222, 16);
    chk("resync_first_discard", 64'(pulse_cnt - p0), 64'd0);
    send_frame(64'h1111, 64'h2222, 16);
    chk("resync_pulses", 64'(pulse_cnt - p0), 64'd1);
    chk("resync_left", 64'(bus.left_channel), 64'h1111);
    chk("resync_right", 64'(bus.right_channel), 64'h2222);
    chk("lost_sticky", 64'(bus.sync_lost), 64'h1);

    // Reset mid-left slot.
    for (int i = 15; i >= 11; i--) sclk_edge(1'b0, 1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midreset_left", 64'(bus.left_channel), 64'h0);
    chk("midreset_right", 64'(bus.right_channel), 64'h0);
    chk("midreset_lost", 64'(bus.sync_lost), 64'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    p0 = pulse_cnt;
    for (int i = 10; i >= 1; i--) sclk_edge(1'b0, 1'b1);
    sclk_edge(1'b1, 1'b1);
    send_slot(1'b1, 64'h4444, 16);
    chk("postreset_no_pulse", 64'(pulse_cnt - p0), 64'd0);
    send_frame(64'h7777, 64'h8888, 16);
    chk("postreset_pulses", 64'(pulse_cnt - p0), 64'd1);
    chk("postreset_left", 64'(bus.left_channel), 64'h7777);
    chk("postreset_right", 64'(bus.right_channel), 64'h8888);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
